// File: rtl/seq_restoring_divider_if.sv
// Run/Done handshake and operand/result bundle shared by the lab ALU sequential units.
interface seq_restoring_divider_if #(
    parameter int WIDTH = 8
);
    logic             Run;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             Busy;
    logic             Done;
    logic             DivByZero;

    modport master (
        output Run, Dividend, Divisor,
        input  Quotient, Remainder, Busy, Done, DivByZero
    );

    modport slave (
        input  Run, Dividend, Divisor,
        output Quotient, Remainder, Busy, Done, DivByZero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock, Run/Done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (adds one FIXUP cycle).
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    seq_restoring_divider_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        ITER,
        ZERO,
`ifdef SEQ_DIVIDER_SIGNED_EN
        FIXUP,
`endif
        HOLD
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic             last_iter;
    logic [WIDTH-1:0] dvd_load;
    logic [WIDTH-1:0] dvs_load;
    logic             unused_r_msb;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             neg_q;
    logic             neg_r;
`endif

    // Subtract as add of inverted divisor with carry-in 1; MSB set means borrow.
    always_comb begin
        shifted   = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        diff      = shifted + (~{1'b0, d_reg}) + {{WIDTH{1'b0}}, 1'b1};
        r_next    = diff[WIDTH] ? shifted : diff;
        q_next    = {q_reg[WIDTH-2:0], ~diff[WIDTH]};
        last_iter = (cnt == CNT_W'(WIDTH - 1));
    end

    // Zero divisor keeps the raw dividend in Q so ZERO can report it unchanged.
    always_comb begin
        dvd_load = bus.Dividend;
        dvs_load = bus.Divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
        if (bus.Divisor != '0) begin
            dvd_load = bus.Dividend[WIDTH-1] ? ('0 - bus.Dividend) : bus.Dividend;
            dvs_load = bus.Divisor[WIDTH-1]  ? ('0 - bus.Divisor)  : bus.Divisor;
        end
`endif
    end

    assign unused_r_msb = r_reg[WIDTH];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (bus.Run) state_next = (bus.Divisor == '0) ? ZERO : ITER;
`ifdef SEQ_DIVIDER_SIGNED_EN
            ITER:  if (last_iter) state_next = FIXUP;
            FIXUP: state_next = HOLD;
`else
            ITER:  if (last_iter) state_next = HOLD;
`endif
            ZERO:  state_next = HOLD;
            HOLD:  if (!bus.Run) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Run) begin
                        q_reg  <= dvd_load;
                        d_reg  <= dvs_load;
                        r_reg  <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_q  <= bus.Dividend[WIDTH-1] ^ bus.Divisor[WIDTH-1];
                        neg_r  <= bus.Dividend[WIDTH-1];
`endif
                    end
                end
                ITER: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    cnt   <= cnt + CNT_W'(1);
`ifndef SEQ_DIVIDER_SIGNED_EN
                    if (last_iter) begin
                        quotient_q  <= q_next;
                        remainder_q <= r_next[WIDTH-1:0];
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end
`endif
                end
`ifdef SEQ_DIVIDER_SIGNED_EN
                FIXUP: begin
                    quotient_q  <= neg_q ? ('0 - q_reg) : q_reg;
                    remainder_q <= neg_r ? ('0 - r_reg[WIDTH-1:0]) : r_reg[WIDTH-1:0];
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                end
`endif
                ZERO: begin
                    quotient_q  <= '1;
                    remainder_q <= q_reg;
                    dbz_q       <= 1'b1;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                end
                HOLD: begin
                    if (!bus.Run) begin
                        done_q <= 1'b0;
                        dbz_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Quotient  = quotient_q;
    assign bus.Remainder = remainder_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.DivByZero = dbz_q;
endmodule
